// File: rtl/fsm_drivers_pkg.sv
// Shared definitions for the state-bank command drivers: FSM encoding,
// health address and stat range constants.
package fsm_drivers_pkg;

   typedef enum logic [1:0] {
      SCAN,
      UP,
      DECAY
   } fsm_state_t;

   localparam int NSTAT_DEFAULT = 5;
   localparam int HEALTH_ADDR   = NSTAT_DEFAULT - 1;
   localparam int STAT_MIN      = 1;
   localparam int STAT_MAX      = 5;

   function automatic int health_addr(input int nstat);
      return nstat - 1;
   endfunction

endpackage

// File: rtl/state_request_ctrl_if.sv
// Command/read-back bus between the request controller and the state bank.
interface state_request_ctrl_if #(
   parameter int BIT_ADDR = 3,
   parameter int BIT_DATO = 3
);

   logic [BIT_ADDR-1:0] state;
   logic                UpState;
   logic                DownState;
   logic [BIT_DATO-1:0] stateValue;

   modport master (
      output state, UpState, DownState,
      input  stateValue
   );

   modport slave (
      input  state, UpState, DownState,
      output stateValue
   );

endinterface

// File: rtl/tick_gen.sv
// Decay timer: free-running divider that pauses while en is low and emits a
// one-cycle tick on the terminal count.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = en && (cnt == W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/state_request_ctrl.sv
// Issues UpState/DownState strobes to the state bank and keeps a registered
// snapshot of every stat by scanning the bank read port between commands.
module state_request_ctrl
   import fsm_drivers_pkg::*;
#(
   parameter int BIT_ADDR = 3,
   parameter int BIT_DATO = 3,
   parameter int NSTAT    = 5,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      btn_up,
   input  logic                      btn_sel,
   input  logic                      decay_en,
   state_request_ctrl_if.master      bank,
   output logic [BIT_ADDR-1:0]       sel_idx,
   output logic [NSTAT*BIT_DATO-1:0] snap,
   output logic                      snap_valid,
   output logic                      alive
);

   localparam logic [BIT_ADDR-1:0] HEALTH   = BIT_ADDR'(health_addr(NSTAT));
   localparam logic [BIT_ADDR-1:0] LAST_SEL = BIT_ADDR'(NSTAT - 2);

   fsm_state_t          fsm;
   logic [BIT_ADDR-1:0] ptr;
   logic [BIT_ADDR-1:0] ptr_next;
   logic                pending_up;
   logic                pending_decay;
   logic                starving;
   logic                starving_now;
   logic                tick;
   logic                enter_up;
   logic                enter_decay;
   logic [BIT_DATO-1:0] snap_r [NSTAT];

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (decay_en),
      .tick (tick)
   );

   assign ptr_next    = (ptr == HEALTH) ? '0 : ptr + 1'b1;
   assign enter_up    = (fsm == SCAN) && pending_up;
   assign enter_decay = (fsm == SCAN) && !pending_up && pending_decay;

   always_comb begin
      starving_now = 1'b0;
      for (int unsigned i = 0; i < NSTAT - 1; i++) begin
         if (snap_r[i] == BIT_DATO'(STAT_MIN)) starving_now = 1'b1;
      end
   end

   // Commands are only chosen from a SCAN cycle, so every UP or DECAY pass is
   // followed by at least one scan cycle before the next command.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm            <= SCAN;
         ptr            <= '0;
         bank.state     <= '0;
         bank.UpState   <= 1'b0;
         bank.DownState <= 1'b0;
         starving       <= 1'b0;
         pending_up     <= 1'b0;
         pending_decay  <= 1'b0;
         sel_idx        <= '0;
      end else begin
         bank.UpState   <= 1'b0;
         bank.DownState <= 1'b0;
         pending_up     <= enter_up ? 1'b0 : (pending_up | btn_up);
         pending_decay  <= enter_decay ? 1'b0 : (pending_decay | tick);
         if (btn_sel) sel_idx <= (sel_idx == LAST_SEL) ? '0 : sel_idx + 1'b1;

         case (fsm)
            SCAN: begin
               if (pending_up) begin
                  fsm          <= UP;
                  bank.state   <= sel_idx;
                  bank.UpState <= 1'b1;
               end else if (pending_decay) begin
                  fsm            <= DECAY;
                  bank.state     <= '0;
                  bank.DownState <= 1'b1;
                  starving       <= starving_now;
               end else begin
                  bank.state <= ptr;
                  ptr        <= ptr_next;
               end
            end
            UP: begin
               fsm        <= SCAN;
               bank.state <= ptr;
               ptr        <= ptr_next;
            end
            DECAY: begin
               if (bank.state == HEALTH) begin
                  fsm        <= SCAN;
                  bank.state <= ptr;
                  ptr        <= ptr_next;
               end else begin
                  bank.state     <= bank.state + 1'b1;
                  bank.DownState <= (bank.state == LAST_SEL) ? starving : 1'b1;
               end
            end
            default: fsm <= SCAN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NSTAT; i++) snap_r[i] <= '0;
         snap_valid <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NSTAT; i++) begin
            if (bank.state == BIT_ADDR'(i)) snap_r[i] <= bank.stateValue;
         end
         if (fsm == SCAN && bank.state == HEALTH) snap_valid <= 1'b1;
      end
   end

   always_comb begin
      snap = '0;
      for (int unsigned i = 0; i < NSTAT; i++) snap[i*BIT_DATO +: BIT_DATO] = snap_r[i];
   end

   assign alive = snap_valid && (snap_r[NSTAT-1] != '0);

endmodule

// File: tb/tb_state_request_ctrl.sv
// Bench for state_request_ctrl: behavioural bank plus a slot-queue reference
// model compared every cycle, with literal checks from hand-worked scenarios.
module tb_state_request_ctrl;
   import fsm_drivers_pkg::*;

   localparam int BA = 3;
   localparam int BD = 3;
   localparam int NS = 5;
   localparam int TD = 16;
   localparam int VW = BA + 2 + BA + NS*BD + 2;

   logic              clk = 1'b0;
   logic              rst, btn_up, btn_sel, decay_en;
   logic [BA-1:0]     sel_idx;
   logic [NS*BD-1:0]  snap;
   logic              snap_valid, alive;

   state_request_ctrl_if #(.BIT_ADDR(BA), .BIT_DATO(BD)) bus ();

   state_request_ctrl #(
      .BIT_ADDR (BA),
      .BIT_DATO (BD),
      .NSTAT    (NS),
      .TICK_DIV (TD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_sel    (btn_sel),
      .decay_en   (decay_en),
      .bank       (bus.master),
      .sel_idx    (sel_idx),
      .snap       (snap),
      .snap_valid (snap_valid),
      .alive      (alive)
   );

   always #5 clk = ~clk;

   // Bank: saturating stats; a health decrement down to STAT_MIN wipes the bank.
   logic [BD-1:0] bankm     [8];
   logic [BD-1:0] load_vals [8];
   logic          load;

   assign bus.stateValue = bankm[bus.state];

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 8; i++) bankm[i] <= load_vals[i];
      end else if (bus.UpState) begin
         if (bankm[bus.state] < BD'(STAT_MAX)) bankm[bus.state] <= bankm[bus.state] + 1'b1;
      end else if (bus.DownState) begin
         if (bus.state == BA'(HEALTH_ADDR) && bankm[bus.state] <= BD'(STAT_MIN + 1)) begin
            for (int i = 0; i < 8; i++) bankm[i] <= '0;
         end else if (bankm[bus.state] > BD'(STAT_MIN)) begin
            bankm[bus.state] <= bankm[bus.state] - 1'b1;
         end
      end
   end

   // Reference model: each cycle is a slot; commands are expanded into slot
   // sequences queued ahead of time, a MARK slot resolves to the next scan.
   typedef enum int {K_SCAN, K_UP, K_DN, K_MARK} kind_t;
   typedef struct {
      logic [BA-1:0] addr;
      kind_t         kind;
      logic          dn;
   } slot_t;

   slot_t         cur;
   slot_t         sched [$];
   int            m_ptr, m_sel, en_cycles;
   bit            m_pu, m_pd, m_valid, model_live = 1'b0;
   logic [BD-1:0] m_snap [NS];
   int            checks = 0;
   int            errors = 0;

   function automatic slot_t mk(input int a, input kind_t k, input logic d);
      slot_t s;
      s.addr = BA'(a);
      s.kind = k;
      s.dn   = d;
      return s;
   endfunction

   task automatic model_step();
      slot_t nxt;
      bit    enter_up, enter_dec, starv, tk;
      if (rst) begin
         cur = mk(0, K_SCAN, 1'b0);
         sched.delete();
         m_ptr = 0; m_sel = 0; en_cycles = 0;
         m_pu = 1'b0; m_pd = 1'b0; m_valid = 1'b0;
         for (int i = 0; i < NS; i++) m_snap[i] = '0;
         model_live = 1'b1;
         return;
      end
      if (!model_live) return;
      enter_up = 1'b0;
      enter_dec = 1'b0;
      starv = 1'b0;
      for (int i = 0; i < NS - 1; i++) if (m_snap[i] == BD'(STAT_MIN)) starv = 1'b1;
      tk = decay_en && (en_cycles % TD == TD - 1);
      if (decay_en) en_cycles++;
      if (sched.size() != 0) begin
         nxt = sched.pop_front();
      end else if (m_pu) begin
         enter_up = 1'b1;
         nxt = mk(m_sel, K_UP, 1'b0);
         sched.push_back(mk(0, K_MARK, 1'b0));
      end else if (m_pd) begin
         enter_dec = 1'b1;
         nxt = mk(0, K_DN, 1'b1);
         for (int k = 1; k < NS - 1; k++) sched.push_back(mk(k, K_DN, 1'b1));
         sched.push_back(mk(NS - 1, K_DN, starv));
         sched.push_back(mk(0, K_MARK, 1'b0));
      end else begin
         nxt = mk(0, K_MARK, 1'b0);
      end
      if (nxt.kind == K_MARK) begin
         nxt = mk(m_ptr, K_SCAN, 1'b0);
         m_ptr = (m_ptr + 1) % NS;
      end
      m_snap[cur.addr] = bankm[cur.addr];
      if (cur.kind == K_SCAN && cur.addr == BA'(NS - 1)) m_valid = 1'b1;
      m_pu = enter_up ? 1'b0 : (m_pu || btn_up);
      m_pd = enter_dec ? 1'b0 : (m_pd || tk);
      if (btn_sel) m_sel = (m_sel == NS - 2) ? 0 : m_sel + 1;
      cur = nxt;
   endtask

   function automatic logic [VW-1:0] model_vec();
      logic [NS*BD-1:0] ps;
      for (int i = 0; i < NS; i++) ps[i*BD +: BD] = m_snap[i];
      return {cur.addr, cur.kind == K_UP, cur.kind == K_DN && cur.dn, BA'(m_sel), ps,
              m_valid, m_valid && (m_snap[NS-1] != '0)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      logic [VW-1:0] dv, mv;
      @(negedge clk);
      if (model_live) begin
         dv = {bus.state, bus.UpState, bus.DownState, sel_idx, snap, snap_valid, alive};
         mv = model_vec();
         checks++;
         if (dv !== mv) begin
            errors++;
            $display("FAIL cycle_model: dut=%h model=%h (t=%0t)", dv, mv, $time);
         end
      end
      @(posedge clk);
      model_step();
      #1;
      btn_up  = 1'b0;
      btn_sel = 1'b0;
      load    = 1'b0;
   endtask

   task automatic wait_dn(input logic [BA-1:0] a);
      int n = 0;
      while (!(bus.DownState && bus.state == a) && n < 100) begin
         cyc();
         n++;
      end
      chk("wait_decay", int'(n < 100), 1);
   endtask

   task automatic load_bank(input int v0, input int v1, input int v2, input int v3, input int v4);
      load_vals[0] = BD'(v0); load_vals[1] = BD'(v1); load_vals[2] = BD'(v2);
      load_vals[3] = BD'(v3); load_vals[4] = BD'(v4);
      for (int i = 5; i < 8; i++) load_vals[i] = '0;
      load = 1'b1;
   endtask

   logic [4:0]  dnseq;
   logic [14:0] aseq;
   int          ups, upat;
   int          sel_exp [4];

   task automatic record_pass();
      for (int k = 0; k < NS; k++) begin
         dnseq[k]         = bus.DownState;
         aseq[k*BA +: BA] = bus.state;
         cyc();
      end
   endtask

   initial begin
      rst = 1'b1; btn_up = 1'b0; btn_sel = 1'b0; decay_en = 1'b0;
      load_bank(5, 5, 5, 5, 5);
      cyc();
      cyc();
      chk("rst_state", int'(bus.state), 0);
      chk("rst_strobes", int'({bus.UpState, bus.DownState}), 0);
      chk("rst_snap", int'(snap), 0);
      chk("rst_flags", int'({sel_idx, snap_valid, alive}), 0);

      rst = 1'b0;
      repeat (6) cyc();
      chk("idle_snap", int'(snap), 32'o55555);
      chk("idle_valid", int'(snap_valid), 1);
      chk("idle_alive", int'(alive), 1);

      decay_en = 1'b1;
      wait_dn(0);
      decay_en = 1'b0;
      record_pass();
      chk("decay_dn_seq", int'(dnseq), 5'b01111);
      chk("decay_addr_seq", int'(aseq), 32'o43210);
      repeat (8) cyc();
      chk("decay_snap", int'(snap), 32'o54444);

      btn_sel = 1'b1; cyc();
      btn_sel = 1'b1; cyc();
      chk("sel_two", int'(sel_idx), 2);
      load_bank(5, 5, 3, 5, 5); cyc();
      repeat (8) cyc();
      chk("pre_up_stat2", int'(snap[2*BD +: BD]), 3);
      btn_up = 1'b1; cyc(); cyc();
      chk("up_strobe", int'({bus.UpState, bus.DownState, bus.state}), 5'b10010);
      repeat (8) cyc();
      chk("up_stat2", int'(snap[2*BD +: BD]), 4);
      load_bank(5, 5, 5, 5, 5); cyc();
      repeat (8) cyc();
      btn_up = 1'b1; cyc(); cyc();
      chk("up_strobe_max", int'({bus.UpState, bus.DownState, bus.state}), 5'b10010);
      repeat (8) cyc();
      chk("up_stat2_max", int'(snap[2*BD +: BD]), 5);

      decay_en = 1'b1;
      wait_dn(1);
      decay_en = 1'b0;
      btn_up = 1'b1; cyc();
      btn_up = 1'b1; cyc();
      ups = 0; upat = -1;
      for (int k = 2; k < 16; k++) begin
         if (bus.UpState) begin
            ups++;
            upat = k;
         end
         cyc();
      end
      chk("mid_decay_ups", ups, 1);
      chk("mid_decay_up_cycle", upat, 5);

      load_bank(1, 4, 4, 4, 2); cyc();
      repeat (8) cyc();
      decay_en = 1'b1;
      wait_dn(0);
      decay_en = 1'b0;
      record_pass();
      chk("starve_dn_seq", int'(dnseq), 5'b11111);
      chk("starve_addr_seq", int'(aseq), 32'o43210);
      repeat (8) cyc();
      chk("starve_snap", int'(snap), 0);
      chk("starve_alive", int'(alive), 0);

      rst = 1'b1; cyc(); cyc();
      rst = 1'b0;
      chk("sel_after_rst", int'(sel_idx), 0);
      sel_exp[0] = 1; sel_exp[1] = 2; sel_exp[2] = 3; sel_exp[3] = 0;
      for (int i = 0; i < 4; i++) begin
         btn_sel = 1'b1;
         cyc();
         chk("sel_step", int'(sel_idx), sel_exp[i]);
      end
      decay_en = 1'b1;
      wait_dn(1);
      rst = 1'b1;
      cyc();
      chk("midpass_rst_strobes", int'({bus.UpState, bus.DownState}), 0);
      chk("midpass_rst_state", int'(bus.state), 0);
      chk("midpass_rst_snap", int'(snap), 0);
      chk("midpass_rst_flags", int'({sel_idx, snap_valid, alive}), 0);
      rst = 1'b0;
      decay_en = 1'b0;
      repeat (10) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
